// File: rtl/iir_pkg.sv
// Shared constants and types for the IIR filter sample transmitter.
package iir_pkg;

    // Q11.20 sample word, same format as the filter data path
    localparam int unsigned IIR_WIDTH    = 32;
    localparam int unsigned IIR_INT_LEN  = 11;
    localparam int unsigned IIR_FRAC_LEN = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tx_state_e;

endpackage

// File: rtl/iir_sync_fifo.sv
// Single-clock FIFO with a fall-through read port and an occupancy count.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module iir_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_level;
    logic             w_push;
    logic             w_pop;

    // Guard against overflow/underflow regardless of the caller
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage array; contents need no reset since level gates every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    assign rdata = r_mem[r_rd_ptr];
    assign level = r_level;
    assign full  = (32'(r_level) == DEPTH);
    assign empty = (r_level == '0);

endmodule

// File: rtl/iir_axis_sample_tx.sv
// AXI-Stream master that sends buffered samples to the IIR filter input in
// frames of frame_len beats, marking the final beat with tlast.
// Optional feature: define IIR_TX_UNDERRUN_CNT_EN to add the underrun_cnt output,
// which counts RUN cycles where a beat could have been issued but the FIFO was empty.
module iir_axis_sample_tx
    import iir_pkg::*;
#(
    parameter int unsigned WIDTH      = IIR_WIDTH,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned LEN_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [LEN_W-1:0]              frame_len,
    input  logic                          in_valid,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          in_ready,
    output logic                          m00_axis_tvalid,
    output logic [WIDTH-1:0]              m00_axis_tdata,
    output logic [WIDTH/8-1:0]            m00_axis_tstrb,
    output logic                          m00_axis_tlast,
    input  logic                          m00_axis_tready,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef IIR_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]                   underrun_cnt
`endif
);

    tx_state_e                        r_state;
    tx_state_e                        w_state_next;
    logic [LEN_W-1:0]                 r_remaining;
    logic                             r_tvalid;
    logic [WIDTH-1:0]                 r_tdata;
    logic                             r_tlast;

    logic [WIDTH-1:0]                 w_fifo_rdata;
    logic [$clog2(FIFO_DEPTH):0]      w_fifo_level;
    logic                             w_fifo_full;
    logic                             w_fifo_empty;
    logic                             w_push;
    logic                             w_start_acc;
    logic                             w_hs;
    logic                             w_load;

    // in_ready comes from the registered level only: a pop in the same cycle
    // does not free a slot for a push while full.
    assign in_ready    = !w_fifo_full;
    assign w_push      = in_valid && in_ready;
    assign w_start_acc = (r_state == IDLE) && start && (frame_len != '0);
    assign w_hs        = r_tvalid && m00_axis_tready;
    assign w_load      = (r_state == RUN) && (r_remaining != '0) && !w_fifo_empty &&
                         (!r_tvalid || m00_axis_tready);

    iir_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_load),
        .wdata (in_data),
        .rdata (w_fifo_rdata),
        .level (w_fifo_level),
        .full  (w_fifo_full),
        .empty (w_fifo_empty)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and status decode
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_start_acc) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                // remaining hits zero only once the tlast beat is loaded
                if ((r_remaining == '0) && w_hs) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Beats still to be loaded in the current frame; starts are only taken in IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_remaining <= '0;
        end else if (w_start_acc) begin
            r_remaining <= frame_len;
        end else if (w_load) begin
            r_remaining <= r_remaining - 1'b1;
        end
    end

    // AXIS output register: reload on pop, otherwise hold until handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tlast  <= 1'b0;
        end else if (w_load) begin
            r_tvalid <= 1'b1;
            r_tdata  <= w_fifo_rdata;
            r_tlast  <= (r_remaining == LEN_W'(1));
        end else if (w_hs) begin
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
        end
    end

    assign m00_axis_tvalid = r_tvalid;
    assign m00_axis_tdata  = r_tdata;
    assign m00_axis_tlast  = r_tlast;
    assign m00_axis_tstrb  = {(WIDTH/8){r_tvalid}};
    assign fifo_level      = w_fifo_level;

`ifdef IIR_TX_UNDERRUN_CNT_EN
    logic [15:0] r_underrun_cnt;
    logic        w_underrun;

    assign w_underrun = (r_state == RUN) && (r_remaining != '0) && w_fifo_empty &&
                        (!r_tvalid || m00_axis_tready);

    // Saturating count of starved beat slots, cleared per frame
    always_ff @(posedge clk) begin
        if (rst || w_start_acc) begin
            r_underrun_cnt <= '0;
        end else if (w_underrun && (r_underrun_cnt != 16'hFFFF)) begin
            r_underrun_cnt <= r_underrun_cnt + 16'd1;
        end
    end

    assign underrun_cnt = r_underrun_cnt;
`endif

endmodule
